fifo_xfer_ctrl: RTL and testbench
=================================

# fifo_xfer_ctrl

Transfer controller for the 8-bit test FIFO. It sequences a complete FIFO exercise: reset pulse, burst fill with an incrementing pattern, then full drain with on-the-fly data checking. It repeats for a programmed number of bursts. It replaces free-running writer/reader logic, and is the single owner of the FIFO's reset, write and read controls.

## Interface
- RST_CYCLES, 4: cycles fifo_rst is held high at sequence start (1..255).
- BURST_LEN, 16: words written per burst (1..65535).
- NUM_BURSTS, 8: bursts per run; 0 means run until stop_req.
- PAT_START, 0: first pattern value (8-bit).
- PAT_STOP, 255: last pattern value before wrap to PAT_START; PAT_STOP ≥ PAT_START.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- n_rst  in  1  reset n_rst, asynchronous, active-low; clock clk.
- start  in  1  one-cycle run request; honoured only in IDLE or DONE.
- stop_req  in  1  level; finish current burst, then go to DONE.
- fifo_rst  out  1  FIFO reset, active-high.
- wr_en  out  1  FIFO write enable.
- wr_data  out  8  write data.
- rd_en  out  1  FIFO read enable.
- rd_data  in  8  FIFO read data; valid the cycle after rd_en.
- full  in  1  FIFO full flag.
- empty  in  1  FIFO empty flag.
- busy  out  1  high in any state except IDLE/DONE.
- done  out  1  high in DONE.
- burst_cnt  out  16  bursts completed this run.
- err_cnt  out  8  read-data mismatches, saturating at 255.

## Operation
- States:
  - IDLE: wait for start. Then go to RESET and clear burst_cnt, err_cnt and both pattern counters.
  - RESET: drive fifo_rst=1 for RST_CYCLES cycles, then go to SETTLE.
  - SETTLE: wait until empty=1 and full=0, then go to FILL.
  - FILL: write. Go to DRAIN when wr_left reaches 0 or full is sampled high (short burst).
  - DRAIN: read until rd_left = 0 and the last check cycle has completed. Then:
    - burst_cnt +1.
    - Go to DONE if stop_req=1 or burst_cnt+1 == NUM_BURSTS (NUM_BURSTS≠0).
    - Otherwise go to FILL.
  - DONE: wait for start, then go to RESET (new run).
- wr_en = (state==FILL) & ~full & (wr_left≠0). This is combinational from registered state and the flag.
- rd_en = (state==DRAIN) & ~empty & (rd_left≠0).
- Counters per burst:
  - Load wr_left with BURST_LEN on entry to FILL.
  - On FILL→DRAIN, rd_left = number of words actually written this burst.
- wr_data is a registered pattern counter. It advances on every cycle with wr_en=1, wrapping PAT_STOP→PAT_START. It is not reset between bursts.
- Checker: exp counter advances on each rd_en. The cycle after rd_en, compare rd_data with exp; on mismatch, err_cnt +1 (saturating).
- stop_req is sampled only at DRAIN completion. It has no effect in other states.
- start in non-idle states is ignored.

## Timing
- Reset values:
  - fifo_rst=0, wr_en=0, rd_en=0, wr_data=PAT_START.
  - busy=0, done=0, burst_cnt=0, err_cnt=0.
  - state IDLE.
- Latency:
  - start → fifo_rst high: 1 cycle.
  - fifo_rst high for exactly RST_CYCLES cycles.
- Write: a word is written on each clk where wr_en=1; wr_data is stable during that cycle.
- Read: rd_data is checked at the rising edge one cycle after rd_en.
- DRAIN exits no earlier than 1 cycle after the last rd_en.
- full rising during FILL: no write that cycle; FILL→DRAIN on the next edge.
- empty during DRAIN with rd_left>0: stall with rd_en=0. Never abort.
- wr_en and rd_en are never high in the same cycle.
- n_rst asserted mid-run: everything returns to reset values immediately. There is no resumption.

## Configuration
- FIFO_XFER_CHECK_EN defined: data checker is present and err_cnt counts mismatches.
- Not defined:
  - exp counter and comparator are removed, rd_data is unused, and err_cnt is tied to 0.
  - The read sequencing, including the one-cycle post-read slot, is unchanged.

## Test plan
- Default parameters, FIFO depth 32, start pulse → fifo_rst high 4 cycles. Then 8 bursts of 16 writes (wr_data 0..15, 16..31, …, 112..127) and 16 reads each; done=1, burst_cnt=8, err_cnt=0.
- BURST_LEN=40, FIFO depth 32 → each FILL ends at full after 32 writes; DRAIN reads exactly 32; err_cnt=0.
- PAT_START=250, PAT_STOP=255, BURST_LEN=8 → wr_data sequence 250..255, 250, 251; checker passes.
- Bench corrupts rd_data to 0xAA on the 3rd read of burst 1 → err_cnt=1 at run end. Forcing 300 mismatches gives err_cnt=255.
- NUM_BURSTS=0, stop_req raised mid-FILL of burst 5 → burst 5 completes its drain; done=1, burst_cnt=5.
- n_rst pulsed during DRAIN → all outputs return to reset values next cycle. A new start replays from fifo_rst with wr_data=PAT_START.

Source files
------------

// File: rtl/fifo_xfer_ctrl.sv
// Transfer controller for the 8-bit test FIFO: reset pulse, burst fill, checked drain, repeat.
// Define FIFO_XFER_CHECK_EN to include the read-data checker; without it err_cnt is tied to 0.
module fifo_xfer_ctrl #(
    parameter logic [7:0]  RST_CYCLES = 8'd4,
    parameter logic [15:0] BURST_LEN  = 16'd16,
    parameter logic [15:0] NUM_BURSTS = 16'd8,
    parameter logic [7:0]  PAT_START  = 8'd0,
    parameter logic [7:0]  PAT_STOP   = 8'd255
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic        stop_req,
    output logic        fifo_rst,
    output logic        wr_en,
    output logic [7:0]  wr_data,
    output logic        rd_en,
    input  logic [7:0]  rd_data,
    input  logic        full,
    input  logic        empty,
    output logic        busy,
    output logic        done,
    output logic [15:0] burst_cnt,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_SETTLE,
        S_FILL,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  rst_cnt_q, rst_cnt_d;
    logic [15:0] wr_left_q, wr_left_d;
    logic [15:0] rd_left_q, rd_left_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [15:0] burst_cnt_q, burst_cnt_d;
    logic        fifo_rst_q, fifo_rst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

`ifdef FIFO_XFER_CHECK_EN
    logic        chk_q, chk_d;
    logic [7:0]  exp_q, exp_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
`endif

    function automatic logic [7:0] pat_next(input logic [7:0] v);
        return (v == PAT_STOP) ? PAT_START : v + 8'd1;
    endfunction

    // Write and read strobes stay combinational so a full/empty flag blocks the access in the same cycle.
    assign wr_en = (state_q == S_FILL) && !full && (wr_left_q != 16'd0);
    assign rd_en = (state_q == S_DRAIN) && !empty && (rd_left_q != 16'd0);

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        wr_left_d   = wr_left_q;
        rd_left_d   = rd_left_q;
        wr_data_d   = wr_data_q;
        burst_cnt_d = burst_cnt_q;
`ifdef FIFO_XFER_CHECK_EN
        chk_d     = rd_en;
        exp_d     = exp_q;
        err_cnt_d = err_cnt_q;
        if (chk_q) begin
            exp_d = pat_next(exp_q);
            if (rd_data != exp_q && err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
`endif

        if (wr_en) begin
            wr_data_d = pat_next(wr_data_q);
            wr_left_d = wr_left_q - 16'd1;
        end
        if (rd_en) begin
            rd_left_d = rd_left_q - 16'd1;
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RESET;
                    rst_cnt_d   = RST_CYCLES;
                    burst_cnt_d = 16'd0;
                    wr_data_d   = PAT_START;
`ifdef FIFO_XFER_CHECK_EN
                    exp_d     = PAT_START;
                    err_cnt_d = 8'd0;
`endif
                end
            end
            S_RESET: begin
                if (rst_cnt_q <= 8'd1) begin
                    state_d = S_SETTLE;
                end else begin
                    rst_cnt_d = rst_cnt_q - 8'd1;
                end
            end
            S_SETTLE: begin
                if (empty && !full) begin
                    state_d   = S_FILL;
                    wr_left_d = BURST_LEN;
                end
            end
            S_FILL: begin
                // A short burst (full seen) drains only what was actually written.
                if (full || wr_left_d == 16'd0) begin
                    state_d   = S_DRAIN;
                    rd_left_d = BURST_LEN - wr_left_d;
                end
            end
            S_DRAIN: begin
                // rd_left hits 0 one edge after the last rd_en, so this cycle is the final check slot.
                if (rd_left_q == 16'd0) begin
                    burst_cnt_d = burst_cnt_q + 16'd1;
                    if (stop_req || (NUM_BURSTS != 16'd0 && burst_cnt_d == NUM_BURSTS)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_FILL;
                        wr_left_d = BURST_LEN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        fifo_rst_d = (state_d == S_RESET);
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            rst_cnt_q   <= 8'd0;
            wr_left_q   <= 16'd0;
            rd_left_q   <= 16'd0;
            wr_data_q   <= PAT_START;
            burst_cnt_q <= 16'd0;
            fifo_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef FIFO_XFER_CHECK_EN
            chk_q     <= 1'b0;
            exp_q     <= PAT_START;
            err_cnt_q <= 8'd0;
`endif
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            wr_left_q   <= wr_left_d;
            rd_left_q   <= rd_left_d;
            wr_data_q   <= wr_data_d;
            burst_cnt_q <= burst_cnt_d;
            fifo_rst_q  <= fifo_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef FIFO_XFER_CHECK_EN
            chk_q     <= chk_d;
            exp_q     <= exp_d;
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

    assign fifo_rst  = fifo_rst_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign burst_cnt = burst_cnt_q;

`ifdef FIFO_XFER_CHECK_EN
    assign err_cnt = err_cnt_q;
`else
    logic unused_rd_data;
    assign unused_rd_data = ^rd_data;
    assign err_cnt        = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_xfer_ctrl.sv
// Bench for fifo_xfer_ctrl: four configurations, each against a depth-32 FIFO model with
// read-data corruption hooks; table-driven full runs plus hand-written corner sequences.
module tb_fifo_xfer_ctrl;

    localparam int N = 4;
`ifdef FIFO_XFER_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    logic [N-1:0] start, stop_req, full, empty;
    wire  [N-1:0] fifo_rst, wr_en, rd_en, busy, done;
    wire  [7:0]   wr_data   [N];
    wire  [15:0]  burst_cnt [N];
    wire  [7:0]   err_cnt   [N];
    logic [7:0]   rd_data   [N];

    // Instance 0: defaults; 1: burst longer than the FIFO; 2: narrow wrapping pattern; 3: endless run.
    fifo_xfer_ctrl u_dut0 (
        .clk(clk), .n_rst(n_rst), .start(start[0]), .stop_req(stop_req[0]),
        .fifo_rst(fifo_rst[0]), .wr_en(wr_en[0]), .wr_data(wr_data[0]), .rd_en(rd_en[0]),
        .rd_data(rd_data[0]), .full(full[0]), .empty(empty[0]), .busy(busy[0]), .done(done[0]),
        .burst_cnt(burst_cnt[0]), .err_cnt(err_cnt[0])
    );
    fifo_xfer_ctrl #(.BURST_LEN(16'd40)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .start(start[1]), .stop_req(stop_req[1]),
        .fifo_rst(fifo_rst[1]), .wr_en(wr_en[1]), .wr_data(wr_data[1]), .rd_en(rd_en[1]),
        .rd_data(rd_data[1]), .full(full[1]), .empty(empty[1]), .busy(busy[1]), .done(done[1]),
        .burst_cnt(burst_cnt[1]), .err_cnt(err_cnt[1])
    );
    fifo_xfer_ctrl #(.BURST_LEN(16'd8), .PAT_START(8'd250), .PAT_STOP(8'd255)) u_dut2 (
        .clk(clk), .n_rst(n_rst), .start(start[2]), .stop_req(stop_req[2]),
        .fifo_rst(fifo_rst[2]), .wr_en(wr_en[2]), .wr_data(wr_data[2]), .rd_en(rd_en[2]),
        .rd_data(rd_data[2]), .full(full[2]), .empty(empty[2]), .busy(busy[2]), .done(done[2]),
        .burst_cnt(burst_cnt[2]), .err_cnt(err_cnt[2])
    );
    fifo_xfer_ctrl #(.NUM_BURSTS(16'd0)) u_dut3 (
        .clk(clk), .n_rst(n_rst), .start(start[3]), .stop_req(stop_req[3]),
        .fifo_rst(fifo_rst[3]), .wr_en(wr_en[3]), .wr_data(wr_data[3]), .rd_en(rd_en[3]),
        .rd_data(rd_data[3]), .full(full[3]), .empty(empty[3]), .busy(busy[3]), .done(done[3]),
        .burst_cnt(burst_cnt[3]), .err_cnt(err_cnt[3])
    );

    // FIFO models, depth 32, registered read data
    logic [7:0]   mem [N][32];
    logic [4:0]   wp [N]  = '{default: '0};
    logic [4:0]   rp [N]  = '{default: '0};
    logic [5:0]   cnt [N] = '{default: '0};
    logic [7:0]   rdq [N] = '{default: '0};
    int           rd_num [N] = '{default: 0};
    logic [N-1:0] corr_aa_q = '0, corr_inv_q = '0;
    logic [N-1:0] fifo_w, fifo_r;
    logic [N-1:0] corrupt_all;
    int           corrupt_at [N];

    always_comb begin
        full   = '0;
        empty  = '0;
        fifo_w = '0;
        fifo_r = '0;
        for (int k = 0; k < N; k++) begin
            full[k]    = (cnt[k] == 6'd32);
            empty[k]   = (cnt[k] == 6'd0);
            fifo_w[k]  = wr_en[k] && (cnt[k] != 6'd32);
            fifo_r[k]  = rd_en[k] && (cnt[k] != 6'd0);
            rd_data[k] = corr_inv_q[k] ? ~rdq[k] : (corr_aa_q[k] ? 8'hAA : rdq[k]);
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (fifo_rst[k]) begin
                cnt[k] <= '0; wp[k] <= '0; rp[k] <= '0; rd_num[k] <= 0;
                corr_aa_q[k] <= 1'b0; corr_inv_q[k] <= 1'b0;
            end else begin
                if (fifo_w[k]) begin
                    mem[k][wp[k]] <= wr_data[k];
                    wp[k] <= wp[k] + 5'd1;
                end
                if (fifo_r[k]) begin
                    rdq[k]        <= mem[k][rp[k]];
                    rp[k]         <= rp[k] + 5'd1;
                    rd_num[k]     <= rd_num[k] + 1;
                    corr_aa_q[k]  <= (rd_num[k] == corrupt_at[k]);
                    corr_inv_q[k] <= corrupt_all[k];
                end
                if (fifo_w[k] && !fifo_r[k]) cnt[k] <= cnt[k] + 6'd1;
                else if (fifo_r[k] && !fifo_w[k]) cnt[k] <= cnt[k] - 6'd1;
            end
        end
    end

    // Per-instance monitors, sampled on the falling edge
    function automatic logic [7:0] pat_start_of(input int k);
        return (k == 2) ? 8'd250 : 8'd0;
    endfunction

    int           wr_total [N] = '{default: 0};
    int           rd_total [N] = '{default: 0};
    int           wr_bad   [N] = '{default: 0};
    int           both_hi  [N] = '{default: 0};
    int           rst_len  [N] = '{default: 0};
    logic [7:0]   pat_exp  [N] = '{default: '0};
    logic [7:0]   last_wr  [N] = '{default: '0};
    logic [N-1:0] prev_rst = '0;

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            prev_rst[k] <= fifo_rst[k];
            if (wr_en[k] && rd_en[k]) both_hi[k] <= both_hi[k] + 1;
            if (fifo_rst[k]) begin
                rst_len[k]  <= prev_rst[k] ? rst_len[k] + 1 : 1;
                wr_total[k] <= 0;
                rd_total[k] <= 0;
                wr_bad[k]   <= 0;
                pat_exp[k]  <= pat_start_of(k);
            end else begin
                if (wr_en[k]) begin
                    if (wr_data[k] !== pat_exp[k]) wr_bad[k] <= wr_bad[k] + 1;
                    pat_exp[k]  <= (pat_exp[k] == 8'd255) ? pat_start_of(k) : pat_exp[k] + 8'd1;
                    wr_total[k] <= wr_total[k] + 1;
                    last_wr[k]  <= wr_data[k];
                end
                if (rd_en[k]) rd_total[k] <= rd_total[k] + 1;
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_start(input int k);
        @(negedge clk); start[k] = 1'b1;
        @(negedge clk); start[k] = 1'b0;
        check($sformatf("inst%0d_start_to_fifo_rst", k), {31'd0, fifo_rst[k]}, 1);
    endtask

    task automatic wait_done(input int k);
        int cyc = 0;
        while (!done[k] && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("inst%0d_done_within_budget", k), {31'd0, done[k]}, 1);
    endtask

    typedef struct {
        int         inst;
        int         corrupt_at;
        int         bursts;
        int         words;
        logic [7:0] last_wr;
        int         err_chk;
    } vec_t;

    vec_t vecs [3];

    initial begin
        vecs[0] = '{inst: 0, corrupt_at: 2,  bursts: 8, words: 128, last_wr: 8'd127, err_chk: 1};
        vecs[1] = '{inst: 1, corrupt_at: -1, bursts: 8, words: 256, last_wr: 8'd255, err_chk: 0};
        vecs[2] = '{inst: 2, corrupt_at: -1, bursts: 8, words: 64,  last_wr: 8'd253, err_chk: 0};

        n_rst       = 1'b1;
        start       = '0;
        stop_req    = '0;
        corrupt_all = '0;
        for (int k = 0; k < N; k++) corrupt_at[k] = -1;
        #1 n_rst = 1'b0;
        @(negedge clk);
        check("rst_fifo_rst",  {31'd0, fifo_rst[0]}, 0);
        check("rst_wr_en",     {31'd0, wr_en[0]}, 0);
        check("rst_rd_en",     {31'd0, rd_en[0]}, 0);
        check("rst_busy",      {31'd0, busy[0]}, 0);
        check("rst_done",      {31'd0, done[0]}, 0);
        check("rst_wr_data",   {24'd0, wr_data[0]}, 0);
        check("rst_wr_data_ps",{24'd0, wr_data[2]}, 250);
        check("rst_burst_cnt", {16'd0, burst_cnt[0]}, 0);
        check("rst_err_cnt",   {24'd0, err_cnt[0]}, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // Complete runs to DONE, one table row per configuration
        for (int i = 0; i < 3; i++) begin
            int k;
            k = vecs[i].inst;
            corrupt_at[k] = vecs[i].corrupt_at;
            run_start(k);
            wait_done(k);
            check($sformatf("run%0d_rst_len", i),   rst_len[k], 4);
            check($sformatf("run%0d_busy", i),      {31'd0, busy[k]}, 0);
            check($sformatf("run%0d_burst_cnt", i), {16'd0, burst_cnt[k]}, vecs[i].bursts);
            check($sformatf("run%0d_err_cnt", i),   {24'd0, err_cnt[k]}, CHK_EN ? vecs[i].err_chk : 0);
            check($sformatf("run%0d_wr_total", i),  wr_total[k], vecs[i].words);
            check($sformatf("run%0d_rd_total", i),  rd_total[k], vecs[i].words);
            check($sformatf("run%0d_wr_pattern", i), wr_bad[k], 0);
            check($sformatf("run%0d_last_wr", i),   {24'd0, last_wr[k]}, {24'd0, vecs[i].last_wr});
            corrupt_at[k] = -1;
        end

        // Endless run stopped during the fifth burst's fill; a stray start must be ignored
        begin
            int cyc = 0;
            run_start(3);
            while (!(burst_cnt[3] == 16'd4 && wr_en[3]) && cyc < 5000) begin
                @(negedge clk);
                cyc++;
            end
            check("stop_reach_burst5_fill", {31'd0, wr_en[3]}, 1);
            stop_req[3] = 1'b1;
            start[3]    = 1'b1;
            @(negedge clk); start[3] = 1'b0;
            check("start_ignored_no_rst", {31'd0, fifo_rst[3]}, 0);
            check("start_ignored_busy",   {31'd0, busy[3]}, 1);
            wait_done(3);
            check("stop_burst_cnt", {16'd0, burst_cnt[3]}, 5);
            check("stop_wr_total",  wr_total[3], 80);
            check("stop_rd_total",  rd_total[3], 80);
            stop_req[3] = 1'b0;
        end

        // Every read corrupted for 300+ reads: error count saturates
        begin
            int cyc = 0;
            corrupt_all[3] = 1'b1;
            run_start(3);
            while (rd_total[3] < 300 && cyc < 20000) begin
                @(negedge clk);
                cyc++;
            end
            check("sat_reached_300_reads", {31'd0, rd_total[3] >= 300}, 1);
            stop_req[3] = 1'b1;
            wait_done(3);
            check("sat_err_cnt",   {24'd0, err_cnt[3]}, CHK_EN ? 255 : 0);
            check("sat_burst_cnt", {16'd0, burst_cnt[3]}, 19);
            stop_req[3]    = 1'b0;
            corrupt_all[3] = 1'b0;
        end

        // Asynchronous reset during the third burst's drain, then a clean replay
        begin
            int cyc = 0;
            run_start(0);
            while (!(burst_cnt[0] == 16'd2 && rd_en[0]) && cyc < 5000) begin
                @(negedge clk);
                cyc++;
            end
            check("nrst_reach_drain", {31'd0, rd_en[0]}, 1);
            n_rst = 1'b0;
            #1;
            check("nrst_busy",      {31'd0, busy[0]}, 0);
            check("nrst_rd_en",     {31'd0, rd_en[0]}, 0);
            check("nrst_burst_cnt", {16'd0, burst_cnt[0]}, 0);
            check("nrst_wr_data",   {24'd0, wr_data[0]}, 0);
            @(negedge clk);
            n_rst = 1'b1;
            repeat (2) @(negedge clk);
            check("nrst_no_resume_busy", {31'd0, busy[0]}, 0);
            check("nrst_no_resume_done", {31'd0, done[0]}, 0);
            run_start(0);
            cyc = 0;
            while (!wr_en[0] && cyc < 1000) begin
                @(negedge clk);
                cyc++;
            end
            check("replay_first_wr_en",   {31'd0, wr_en[0]}, 1);
            check("replay_first_wr_data", {24'd0, wr_data[0]}, 0);
            wait_done(0);
            check("replay_burst_cnt",  {16'd0, burst_cnt[0]}, 8);
            check("replay_err_cnt",    {24'd0, err_cnt[0]}, 0);
            check("replay_wr_total",   wr_total[0], 128);
            check("replay_wr_pattern", wr_bad[0], 0);
        end

        check("wr_rd_never_both", both_hi[0] + both_hi[1] + both_hi[2] + both_hi[3], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
